// File: rtl/vga_timing_pkg.sv
// Shared constants and control bundle for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } vga_ctrl_t;

  // Bundle value outside any sync/visible interval.
  function automatic vga_ctrl_t ctrl_idle(input logic sync_active);
    vga_ctrl_t c;
    c.hsync       = ~sync_active;
    c.vsync       = ~sync_active;
    c.de          = 1'b0;
    c.line_start  = 1'b0;
    c.frame_start = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enable qualified delay line for the sync/enable/strobe bundle.
// DEPTH=0 is a plain wire with no register.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 0
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_en,
  input  vga_ctrl_t i_idle,
  input  vga_ctrl_t i_ctrl,
  output vga_ctrl_t o_ctrl
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = ^{i_clk, i_reset, i_en, i_idle};
    assign o_ctrl   = i_ctrl;
  end else begin : g_pipe
    vga_ctrl_t r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_stage[i] <= i_idle;
        end
      end else if (i_en) begin
        r_stage[0] <= i_ctrl;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign o_ctrl = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel counters, registered decode
// and a delay line that aligns sync/enable with a downstream colour pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned PIPE_DELAY  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic [COORD_W-1:0] colPos,
  output logic [COORD_W-1:0] rowPos,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               display_enable,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((((H_TOTAL - 1) >> COORD_W) != 0) || (((V_TOTAL - 1) >> COORD_W) != 0)) begin : g_coord_chk
    $error("vga_timing_gen: COORD_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end

  localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT        = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT        = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SYNC_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  vga_ctrl_t          r_ctrl;
  vga_ctrl_t          w_ctrl;
  vga_ctrl_t          w_idle;
  vga_ctrl_t          w_ctrl_out;
  logic               w_h_wrap;
  logic               w_v_wrap;

  assign w_idle   = ctrl_idle(SYNC_ACTIVE);
  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_en) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + COORD_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + COORD_W'(1);
      end
    end
  end

  always_comb begin
    w_ctrl             = w_idle;
    w_ctrl.de          = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_ctrl.hsync       = ((r_h_cnt >= H_SYNC_FIRST) && (r_h_cnt <= H_SYNC_LAST)) ?
                         SYNC_ACTIVE : ~SYNC_ACTIVE;
    // Vertical decode uses only the line count, so VSYNC edges land on colPos==0.
    w_ctrl.vsync       = ((r_v_cnt >= V_SYNC_FIRST) && (r_v_cnt <= V_SYNC_LAST)) ?
                         SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_ctrl.line_start  = (r_h_cnt == '0);
    w_ctrl.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_ctrl <= w_idle;
    end else if (pix_en) begin
      r_col  <= r_h_cnt;
      r_row  <= r_v_cnt;
      r_ctrl <= w_ctrl;
    end
  end

  vga_sync_delay #(
    .DEPTH(PIPE_DELAY)
  ) u_delay (
    .i_clk  (clk),
    .i_reset(reset),
    .i_en   (pix_en),
    .i_idle (w_idle),
    .i_ctrl (r_ctrl),
    .o_ctrl (w_ctrl_out)
  );

  assign colPos         = r_col;
  assign rowPos         = r_row;
  assign HSYNC          = w_ctrl_out.hsync;
  assign VSYNC          = w_ctrl_out.vsync;
  assign display_enable = w_ctrl_out.de;
  assign line_start     = w_ctrl_out.line_start;
  assign frame_start    = w_ctrl_out.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reference model derived from the pixel count
// since reset, a directed vector table, and hand sequences for corner cases.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, d;
    bit sa;
  } cfg_t;

  typedef struct {
    int col, row;
    bit hs, vs, de, ls, fs;
  } exp_t;

  typedef struct {
    bit rst, pe;
    int col, row;
    bit hs, vs, de, ls, fs;
  } vec_t;

  // Small raster: 30 pixels x 15 lines = 450 pixels per frame.
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVA = 8, SVF = 2, SVS = 2, SVB = 3;
  localparam int SCW = 5;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  bit rst_s = 1'b1, pe_s = 1'b0;
  bit rst_d = 1'b1, pe_d = 1'b0;
  bit rst_f = 1'b1, pe_f = 1'b0;

  logic [SCW-1:0] col_s, row_s, col_d, row_d;
  logic [9:0]     col_f, row_f;
  logic hs_s, vs_s, de_s, ls_s, fs_s;
  logic hs_d, vs_d, de_d, ls_d, fs_d;
  logic hs_f, vs_f, de_f, ls_f, fs_f;

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_ACTIVE(1'b0), .COORD_W(SCW), .PIPE_DELAY(0)
  ) u_small (
    .clk(clk), .reset(rst_s), .pix_en(pe_s), .colPos(col_s), .rowPos(row_s),
    .HSYNC(hs_s), .VSYNC(vs_s), .display_enable(de_s), .line_start(ls_s),
    .frame_start(fs_s)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_ACTIVE(1'b1), .COORD_W(SCW), .PIPE_DELAY(3)
  ) u_dly (
    .clk(clk), .reset(rst_d), .pix_en(pe_d), .colPos(col_d), .rowPos(row_d),
    .HSYNC(hs_d), .VSYNC(vs_d), .display_enable(de_d), .line_start(ls_d),
    .frame_start(fs_d)
  );

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_f), .pix_en(pe_f), .colPos(col_f), .rowPos(row_f),
    .HSYNC(hs_f), .VSYNC(vs_f), .display_enable(de_f), .line_start(ls_f),
    .frame_start(fs_f)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cfg_t mk_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit sa,
                                  input int d);
    cfg_t c;
    c.ha = ha; c.hf = hf; c.hs = hs; c.hb = hb;
    c.va = va; c.vf = vf; c.vs = vs; c.vb = vb;
    c.sa = sa; c.d = d;
    return c;
  endfunction

  function automatic vec_t mk_vec(input bit rst, pe, input int col, row,
                                  input bit hs, vs, de, ls, fs);
    vec_t v;
    v.rst = rst; v.pe = pe; v.col = col; v.row = row;
    v.hs = hs; v.vs = vs; v.de = de; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  // Outputs after n accepted pixels since reset: coordinates of pixel n-1,
  // control bundle of pixel n-1-d (idle until that pixel exists).
  function automatic exp_t model(input cfg_t c, input int n);
    exp_t e;
    int ht, vt, q, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e.col = 0; e.row = 0;
    e.hs = ~c.sa; e.vs = ~c.sa; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    if (n > 0) begin
      e.col = (n - 1) % ht;
      e.row = ((n - 1) / ht) % vt;
    end
    q = n - 1 - c.d;
    if (n > 0 && q >= 0) begin
      h = q % ht;
      v = (q / ht) % vt;
      e.de = (h < c.ha) && (v < c.va);
      e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.sa : ~c.sa;
      e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.sa : ~c.sa;
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input int col, row,
                         input bit hs, vs, de, ls, fs);
    check({tag, ".col"}, col, e.col);
    check({tag, ".row"}, row, e.row);
    check({tag, ".hsync"}, int'(hs), int'(e.hs));
    check({tag, ".vsync"}, int'(vs), int'(e.vs));
    check({tag, ".de"}, int'(de), int'(e.de));
    check({tag, ".line_start"}, int'(ls), int'(e.ls));
    check({tag, ".frame_start"}, int'(fs), int'(e.fs));
  endtask

  cfg_t cfg_s, cfg_d, cfg_f;
  int n_s = 0, n_d = 0, n_f = 0;
  bit v_s = 1'b0, v_d = 1'b0, v_f = 1'b0;

  initial begin
    cfg_s = mk_cfg(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, 0);
    cfg_d = mk_cfg(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 3);
    cfg_f = mk_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 0);
  end

  // Accepted-pixel counters for the model; v_* marks a reset has been seen.
  always @(posedge clk) begin
    if (rst_s) n_s <= 0; else if (pe_s) n_s <= n_s + 1;
    if (rst_d) n_d <= 0; else if (pe_d) n_d <= n_d + 1;
    if (rst_f) n_f <= 0; else if (pe_f) n_f <= n_f + 1;
    v_s <= v_s | rst_s;
    v_d <= v_d | rst_d;
    v_f <= v_f | rst_f;
  end

  always @(negedge clk) begin
    if (v_s) compare("m_small", model(cfg_s, n_s), int'(col_s), int'(row_s),
                     hs_s, vs_s, de_s, ls_s, fs_s);
    if (v_d) compare("m_dly", model(cfg_d, n_d), int'(col_d), int'(row_d),
                     hs_d, vs_d, de_d, ls_d, fs_d);
    if (v_f) compare("m_def", model(cfg_f, n_f), int'(col_f), int'(row_f),
                     hs_f, vs_f, de_f, ls_f, fs_f);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_d(input int sel, input bit lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if ((sel == 0 ? de_d : hs_d) == lvl) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  vec_t tbl [10];
  int   c_de, c_hs, c_vs, c_ls, c_fs, vs_edges, vs_bad, rises, first_rise, period, hs_bad;
  bit   prev_vs, prev_fs, ok;

  initial begin
    tbl[0] = mk_vec(1, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[1] = mk_vec(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[2] = mk_vec(0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[3] = mk_vec(0, 1, 0, 0, 1, 1, 1, 1, 1);
    tbl[4] = mk_vec(0, 0, 0, 0, 1, 1, 1, 1, 1);
    tbl[5] = mk_vec(0, 1, 1, 0, 1, 1, 1, 0, 0);
    tbl[6] = mk_vec(0, 0, 1, 0, 1, 1, 1, 0, 0);
    tbl[7] = mk_vec(0, 1, 2, 0, 1, 1, 1, 0, 0);
    tbl[8] = mk_vec(1, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[9] = mk_vec(0, 1, 0, 0, 1, 1, 1, 1, 1);

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst_s = tbl[i].rst;
      pe_s  = tbl[i].pe;
      @(negedge clk);
      check($sformatf("tbl%0d.col", i), int'(col_s), tbl[i].col);
      check($sformatf("tbl%0d.row", i), int'(row_s), tbl[i].row);
      check($sformatf("tbl%0d.hsync", i), int'(hs_s), int'(tbl[i].hs));
      check($sformatf("tbl%0d.vsync", i), int'(vs_s), int'(tbl[i].vs));
      check($sformatf("tbl%0d.de", i), int'(de_s), int'(tbl[i].de));
      check($sformatf("tbl%0d.ls", i), int'(ls_s), int'(tbl[i].ls));
      check($sformatf("tbl%0d.fs", i), int'(fs_s), int'(tbl[i].fs));
    end

    // One full frame census at pix_en=1, starting on pixel 0.
    c_de = 0; c_hs = 0; c_vs = 0; c_ls = 0; c_fs = 0; vs_edges = 0; vs_bad = 0;
    prev_vs = vs_s;
    for (int i = 0; i < 450; i++) begin
      c_de += int'(de_s);
      c_hs += int'(!hs_s);
      c_vs += int'(!vs_s);
      c_ls += int'(ls_s);
      c_fs += int'(fs_s);
      if (i > 0 && vs_s != prev_vs) begin
        vs_edges++;
        if (col_s != 0) vs_bad++;
      end
      prev_vs = vs_s;
      @(negedge clk);
    end
    check("census.de", c_de, SHA * SVA);
    check("census.hsync_low", c_hs, SHS * 15);
    check("census.vsync_low", c_vs, SVS * 30);
    check("census.line_start", c_ls, 15);
    check("census.frame_start", c_fs, 1);
    check("census.vsync_edges", vs_edges, 2);
    check("census.vsync_edge_off_col0", vs_bad, 0);
    check("census.next_frame_start", int'(fs_s), 1);

    repeat (1500) begin
      pe_s = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    // pix_en every 4th clk: frame period becomes 4 x 450 clk.
    rises = 0; first_rise = 0; period = 0;
    prev_fs = fs_s;
    for (int i = 0; i < 4000; i++) begin
      pe_s = (i % 4 == 0);
      @(negedge clk);
      if (fs_s && !prev_fs) begin
        if (rises == 0) first_rise = i;
        else if (rises == 1) period = i - first_rise;
        rises++;
      end
      prev_fs = fs_s;
    end
    check("div4.frame_rises", int'(rises >= 2), 1);
    check("div4.frame_period", period, 1800);

    // Mid-frame reset.
    pe_s = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (col_s == 10 && row_s == 5) ok = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid.reached", int'(ok), 1);
    rst_s = 1'b1;
    @(negedge clk);
    check("rst_mid.col", int'(col_s), 0);
    check("rst_mid.row", int'(row_s), 0);
    check("rst_mid.de", int'(de_s), 0);
    check("rst_mid.hsync", int'(hs_s), 1);
    pe_s = 1'b0;
    @(negedge clk);
    check("rst_hold.fs", int'(fs_s), 0);
    rst_s = 1'b0;
    pe_s  = 1'b1;
    @(negedge clk);
    check("rst_rel.col", int'(col_s), 0);
    check("rst_rel.fs", int'(fs_s), 1);
    check("rst_rel.ls", int'(ls_s), 1);
    pe_s = 1'b0;

    // PIPE_DELAY=3, SYNC_ACTIVE=1: syncs idle low during reset.
    check("dly_rst.hsync", int'(hs_d), 0);
    check("dly_rst.vsync", int'(vs_d), 0);
    check("dly_rst.de", int'(de_d), 0);
    rst_d = 1'b0;
    pe_d  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dly_fill.col", int'(col_d), k);
      check("dly_fill.de", int'(de_d), 0);
      check("dly_fill.fs", int'(fs_d), 0);
    end
    @(negedge clk);
    check("dly_first.col", int'(col_d), 3);
    check("dly_first.de", int'(de_d), 1);
    check("dly_first.fs", int'(fs_d), 1);
    wait_d(0, 1'b0, ok);
    check("dly_de_fall.seen", int'(ok), 1);
    check("dly_de_fall.col", int'(col_d), SHA + 3);
    wait_d(1, 1'b1, ok);
    check("dly_hs_rise.seen", int'(ok), 1);
    check("dly_hs_rise.col", int'(col_d), SHA + SHF + 3);
    wait_d(1, 1'b0, ok);
    check("dly_hs_fall.seen", int'(ok), 1);
    check("dly_hs_fall.col", int'(col_d), SHA + SHF + SHS + 3);
    wait_d(0, 1'b1, ok);
    check("dly_de_rise.seen", int'(ok), 1);
    check("dly_de_rise.col", int'(col_d), 3);
    check("dly_de_rise.row", int'(row_d), 1);

    repeat (1500) begin
      pe_d = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    // Reset while VSYNC is active: both syncs must drop to idle.
    pe_d = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (col_d == 10 && row_d == 10) ok = 1'b1;
      else @(negedge clk);
    end
    check("dly_rst_mid.reached", int'(ok), 1);
    check("dly_rst_mid.vsync_before", int'(vs_d), 1);
    rst_d = 1'b1;
    repeat (3) begin
      pe_d = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("dly_rst_mid.vsync", int'(vs_d), 0);
      check("dly_rst_mid.hsync", int'(hs_d), 0);
      check("dly_rst_mid.col", int'(col_d), 0);
    end
    rst_d = 1'b0;
    repeat (600) begin
      pe_d = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    pe_d = 1'b0;

    // Default 640x480 timing over two lines.
    rst_f = 1'b0;
    pe_f  = 1'b1;
    @(negedge clk);
    check("def_first.fs", int'(fs_f), 1);
    check("def_first.de", int'(de_f), 1);
    c_hs = 0; c_ls = 0; c_de = 0; hs_bad = 0;
    for (int i = 0; i < 1600; i++) begin
      c_hs += int'(!hs_f);
      c_ls += int'(ls_f);
      c_de += int'(de_f);
      if (!hs_f && (col_f < 656 || col_f > 751)) hs_bad++;
      @(negedge clk);
    end
    check("def.hsync_low", c_hs, 192);
    check("def.hsync_outside_656_751", hs_bad, 0);
    check("def.line_start", c_ls, 2);
    check("def.de", c_de, 1280);
    check("def.line2_start_col", int'(col_f), 0);
    check("def.line2_start_ls", int'(ls_f), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, successor to the fixed 640x480 `vga` block. It sits between the PLL pixel clock and the pattern/sprite generators. It produces registered pixel coordinates, sync, display-enable and line/frame strobes. It adds:
- a pixel-clock enable, so the system clock can run faster than the pixel rate;
- configurable sync polarity;
- a delay line that re-aligns sync and enable with a multi-cycle colour pipeline.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 1'b0, level driven on HSYNC/VSYNC during the sync interval
- `COORD_W`, 10, width of colPos/rowPos; must hold H_TOTAL-1 and V_TOTAL-1 (elaboration-time assertion)
- `PIPE_DELAY`, 0, extra pixel periods of delay on HSYNC/VSYNC/display_enable/strobes, relative to colPos/rowPos

Ports:
- `clk` input 1: system clock
- `reset` input 1: synchronous, active-high reset
- `pix_en` input 1: advance one pixel this cycle; tie high when clk is the pixel clock
- `colPos` output COORD_W: horizontal counter, 0..H_TOTAL-1
- `rowPos` output COORD_W: vertical counter, 0..V_TOTAL-1
- `HSYNC` output 1: horizontal sync, delayed by PIPE_DELAY
- `VSYNC` output 1: vertical sync, delayed by PIPE_DELAY
- `display_enable` output 1: pixel is in the visible area, delayed by PIPE_DELAY
- `line_start` output 1: colPos==0 pixel, delayed by PIPE_DELAY
- `frame_start` output 1: colPos==0 && rowPos==0 pixel, delayed by PIPE_DELAY

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Region order per line and per frame: active, front porch, sync, back porch.
- Counters `h_cnt` and `v_cnt` advance only on pix_en=1:
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on that h wrap.
  - v_cnt wraps from V_TOTAL-1 to 0 when the h and v wraps coincide.
- Output stage (registered, loads only on pix_en=1) decodes the current counters:
  - colPos=h_cnt, rowPos=v_cnt
  - de = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs = SYNC_ACTIVE when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_ACTIVE
  - vs is the same decode on v_cnt with the V parameters, evaluated per whole line
  - line_start = h_cnt==0
  - frame_start = h_cnt==0 && v_cnt==0
- The 5-bit bundle {hs, vs, de, line_start, frame_start} passes through a PIPE_DELAY-stage delay line. Every stage shifts only on pix_en=1.
- PIPE_DELAY=0 means a direct connection, with no added register.
- colPos/rowPos are never delayed. Consumers compute colour from them in PIPE_DELAY stages, and that colour then aligns with display_enable.
- pix_en=0: every register holds its value, so all outputs, strobes included, hold for the whole pixel period.

## Timing
- Reset values (outputs on the edge after reset is sampled high):
  - colPos=0, rowPos=0
  - HSYNC=VSYNC=~SYNC_ACTIVE
  - display_enable=0, line_start=0, frame_start=0
  - all delay-line stages cleared to this inactive bundle
  - h_cnt=v_cnt=0
- Reset dominates pix_en, and it takes effect mid-line and mid-frame without finishing the current line.
- First pix_en cycle after release: outputs show colPos=0/rowPos=0 after that edge.
- With PIPE_DELAY=0, display_enable=1 and line_start=frame_start=1 on that same edge.
- The delayed signals first become valid after PIPE_DELAY+1 pix_en cycles.
- Latency counter→outputs: 1 pix_en cycle for coordinates, 1+PIPE_DELAY for the delayed signals.
- Strobes are one pixel period wide, which is one pix_en-qualified cycle.
- HSYNC is active for exactly H_SYNC pixel periods per line.
- VSYNC is active for exactly V_SYNC×H_TOTAL pixel periods, and its transitions coincide with colPos==0.

## Structure
- Package `vga_timing_pkg`:
  - the 640x480@60 default constants (H_/V_ ACTIVE/FP/SYNC/BP)
  - a packed typedef `vga_ctrl_t` {hsync, vsync, de, line_start, frame_start} used by the delay line
- Sub-module `vga_sync_delay`: parametrised by DEPTH, carries `vga_ctrl_t`. It has clk, reset, en and an inactive reset value, and DEPTH=0 generates a pass-through.

## Test plan
- **Reset then free run** (pix_en=1, defaults): after release, frame_start=1 at colPos=0/rowPos=0. Next frame_start 420000 cycles later. display_enable high for 640×480=307200 cycles per frame.
- **HSYNC placement**: HSYNC low exactly for colPos 656..751 of each line and high elsewhere. line_start every 800 cycles.
- **VSYNC placement**: VSYNC low from rowPos 490 colPos 0 through rowPos 491 colPos 799, i.e. 1600 cycles.
- **pix_en=1 every 4th cycle**: every output holds for 4 clk. Frame period 1680000 clk. Counters never skip or repeat.
- **PIPE_DELAY=3**: display_enable rises when colPos==3 (pix_en=1) and falls when colPos==643. HSYNC edges shift by 3 pixels likewise.
- **Reset asserted at rowPos=200, colPos=300**: the next edge gives reset values. After release the sequence restarts from 0,0 with frame_start=1. With SYNC_ACTIVE=1, syncs idle low during reset.
